// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, branch flush and EX operand forwarding control for a classic
// five-stage pipeline, with saturating stall/flush statistics counters.
module pipeline_hazard_unit #(
  parameter int REG_NUM_WIDTH     = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     idValid,
  input  logic [REG_NUM_WIDTH-1:0] idRs,
  input  logic [REG_NUM_WIDTH-1:0] idRt,
  input  logic                     idRsUsed,
  input  logic                     idRtUsed,
  input  logic                     idWrEnable,
  input  logic [REG_NUM_WIDTH-1:0] idWrNum,
  input  logic                     idIsLoad,
  input  logic                     brTaken,
  input  logic [DATA_WIDTH-1:0]    wbData,
  output logic                     stall,
  output logic                     flush,
  output logic [1:0]               fwdSelA,
  output logic [1:0]               fwdSelB,
  output logic [DATA_WIDTH-1:0]    lateData,
  output logic [CNT_WIDTH-1:0]     stallCount,
  output logic [CNT_WIDTH-1:0]     flushCount
);

  localparam logic [2:0]               STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [REG_NUM_WIDTH-1:0] REG_ZERO     = {REG_NUM_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX      = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE      = CNT_WIDTH'(1);

  // Stage shadow records (WB/LATE isLoad is never consulted, so it is not kept)
  logic                     r_ex_valid, r_ex_wr, r_ex_load, r_ex_rs_used, r_ex_rt_used;
  logic [REG_NUM_WIDTH-1:0] r_ex_num, r_ex_rs, r_ex_rt;
  logic                     r_mem_valid, r_mem_wr, r_mem_load;
  logic [REG_NUM_WIDTH-1:0] r_mem_num;
  logic                     r_wb_valid, r_wb_wr;
  logic [REG_NUM_WIDTH-1:0] r_wb_num;
  logic                     r_late_valid, r_late_wr;
  logic [REG_NUM_WIDTH-1:0] r_late_num;
  logic [DATA_WIDTH-1:0]    r_late_data;
  logic [2:0]               r_stall_cnt;
  logic [CNT_WIDTH-1:0]     r_stall_count, r_flush_count;

  logic w_id_rs_hit, w_id_rt_hit, w_hazard, w_flush, w_stall;
  logic w_a_mem, w_a_wb, w_a_late, w_b_mem, w_b_wb, w_b_late;

  function automatic logic src_match(
    input logic                     used,
    input logic [REG_NUM_WIDTH-1:0] src,
    input logic                     valid,
    input logic                     wr,
    input logic [REG_NUM_WIDTH-1:0] num
  );
    return used && (src != REG_ZERO) && valid && wr && (num == src);
  endfunction

  // A load result sitting in MEM is not yet available, so it selects the register file
  function automatic logic [1:0] fwd_pick(
    input logic mem_hit,
    input logic mem_load,
    input logic wb_hit,
    input logic late_hit
  );
    logic [1:0] sel;
    if (mem_hit) begin
      sel = mem_load ? 2'b00 : 2'b01;
    end else if (wb_hit) begin
      sel = 2'b10;
    end else if (late_hit) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_id_rs_hit = src_match(idRsUsed, idRs, r_ex_valid, r_ex_wr, r_ex_num) && r_ex_load;
  assign w_id_rt_hit = src_match(idRtUsed, idRt, r_ex_valid, r_ex_wr, r_ex_num) && r_ex_load;
  assign w_hazard    = idValid && (w_id_rs_hit || w_id_rt_hit);
  assign w_flush     = brTaken && r_mem_valid;
  assign w_stall     = (w_hazard || (r_stall_cnt != 3'd0)) && !w_flush;

  assign w_a_mem  = src_match(r_ex_rs_used, r_ex_rs, r_mem_valid,  r_mem_wr,  r_mem_num);
  assign w_a_wb   = src_match(r_ex_rs_used, r_ex_rs, r_wb_valid,   r_wb_wr,   r_wb_num);
  assign w_a_late = src_match(r_ex_rs_used, r_ex_rs, r_late_valid, r_late_wr, r_late_num);
  assign w_b_mem  = src_match(r_ex_rt_used, r_ex_rt, r_mem_valid,  r_mem_wr,  r_mem_num);
  assign w_b_wb   = src_match(r_ex_rt_used, r_ex_rt, r_wb_valid,   r_wb_wr,   r_wb_num);
  assign w_b_late = src_match(r_ex_rt_used, r_ex_rt, r_late_valid, r_late_wr, r_late_num);

  assign stall      = w_stall;
  assign flush      = w_flush;
  assign fwdSelA    = fwd_pick(w_a_mem, r_mem_load, w_a_wb, w_a_late);
  assign fwdSelB    = fwd_pick(w_b_mem, r_mem_load, w_b_wb, w_b_late);
  assign lateData   = r_late_data;
  assign stallCount = r_stall_count;
  assign flushCount = r_flush_count;

  // Shift the stage records, injecting bubbles on stall/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_wr      <= 1'b0;
      r_ex_load    <= 1'b0;
      r_ex_num     <= REG_ZERO;
      r_ex_rs      <= REG_ZERO;
      r_ex_rt      <= REG_ZERO;
      r_ex_rs_used <= 1'b0;
      r_ex_rt_used <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_load   <= 1'b0;
      r_mem_num    <= REG_ZERO;
      r_wb_valid   <= 1'b0;
      r_wb_wr      <= 1'b0;
      r_wb_num     <= REG_ZERO;
      r_late_valid <= 1'b0;
      r_late_wr    <= 1'b0;
      r_late_num   <= REG_ZERO;
      r_late_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ex_valid   <= idValid && !w_stall && !w_flush;
      r_ex_wr      <= idWrEnable;
      r_ex_load    <= idIsLoad;
      r_ex_num     <= idWrNum;
      r_ex_rs      <= idRs;
      r_ex_rt      <= idRt;
      r_ex_rs_used <= idRsUsed;
      r_ex_rt_used <= idRtUsed;
      r_mem_valid  <= r_ex_valid && !w_flush;
      r_mem_wr     <= r_ex_wr;
      r_mem_load   <= r_ex_load;
      r_mem_num    <= r_ex_num;
      r_wb_valid   <= r_mem_valid;
      r_wb_wr      <= r_mem_wr;
      r_wb_num     <= r_mem_num;
      r_late_valid <= r_wb_valid;
      r_late_wr    <= r_wb_wr;
      r_late_num   <= r_wb_num;
      if (r_wb_valid && r_wb_wr) begin
        r_late_data <= wbData;
      end else begin
        r_late_data <= r_late_data;
      end
    end
  end

  // Bubble countdown: the hazard cycle itself is the first bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 3'd0;
    end else if (w_flush) begin
      r_stall_cnt <= 3'd0;
    end else if (r_stall_cnt != 3'd0) begin
      r_stall_cnt <= r_stall_cnt - 3'd1;
    end else if (w_hazard) begin
      r_stall_cnt <= STALL_RELOAD;
    end else begin
      r_stall_cnt <= 3'd0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= {CNT_WIDTH{1'b0}};
      r_flush_count <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_flush && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: a default instance (one bubble) and a
// two-bubble instance with 2-bit counters share the same ID-stage stimulus.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid, idRsUsed, idRtUsed, idWrEnable, idIsLoad, brTaken;
  logic [4:0]  idRs, idRt, idWrNum;
  logic [31:0] wbData;

  logic        stall1, flush1, stall2, flush2;
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic [31:0] late1, late2, sc1, fc1;
  logic [1:0]  sc2, fc2;

  int total = 0;
  int bad   = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_unit u_dut1 (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idRsUsed(idRsUsed), .idRtUsed(idRtUsed), .idWrEnable(idWrEnable),
    .idWrNum(idWrNum), .idIsLoad(idIsLoad), .brTaken(brTaken), .wbData(wbData),
    .stall(stall1), .flush(flush1), .fwdSelA(fa1), .fwdSelB(fb1),
    .lateData(late1), .stallCount(sc1), .flushCount(fc1)
  );

  pipeline_hazard_unit #(.LOAD_STALL_CYCLES(2), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idRsUsed(idRsUsed), .idRtUsed(idRtUsed), .idWrEnable(idWrEnable),
    .idWrNum(idWrNum), .idIsLoad(idIsLoad), .brTaken(brTaken), .wbData(wbData),
    .stall(stall2), .flush(flush2), .fwdSelA(fa2), .fwdSelB(fb2),
    .lateData(late2), .stallCount(sc2), .flushCount(fc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu, input logic wr,
                       input logic [4:0] wn, input logic ld);
    idValid = v; idRs = rs; idRt = rt; idRsUsed = rsu; idRtUsed = rtu;
    idWrEnable = wr; idWrNum = wn; idIsLoad = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic observe(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %0h expected nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %0h expected %0h", t, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; brTaken = 1'b0; wbData = 32'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    push("rst_stall", 64'd0); push("rst_flush", 64'd0); push("rst_fwdA", 64'd0);
    push("rst_fwdB", 64'd0); push("rst_late", 64'd0); push("rst_scnt", 64'd0);
    push("rst_fcnt", 64'd0);
    #1;
    observe(64'(stall1)); observe(64'(flush1)); observe(64'(fa1)); observe(64'(fb1));
    observe(64'(late1)); observe(64'(sc1)); observe(64'(fc1));
    rst = 1'b0;

    // ALU producer r1 -> consumer add r2,r1,r3: MEM forward, no stall
    tick();
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);
    push("alu_stall", 64'd0); #1; observe(64'(stall1));
    tick();
    idle();
    push("alu_fwdA", 64'd1); push("alu_fwdB", 64'd0); push("alu_stall_ex", 64'd0);
    #1; observe(64'(fa1)); observe(64'(fb1)); observe(64'(stall1));
    repeat (4) tick();

    // lw r3 -> add r4,r3,r5: one bubble, then WB forward
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    push("lu1_stall_c1", 64'd1); push("lu1_d2_stall_c1", 64'd1);
    #1; observe(64'(stall1)); observe(64'(stall2));
    tick();
    push("lu1_stall_c2", 64'd0); push("lu1_scnt_c2", 64'd1);
    #1; observe(64'(stall1)); observe(64'(sc1));
    tick();
    idle(); wbData = 32'hDEAD_BEEF;
    push("lu1_fwdA", 64'd2); push("lu1_fwdB", 64'd0); push("lu1_stall_ex", 64'd0);
    push("lu1_scnt", 64'd1); push("lu1_d2_scnt", 64'd2);
    #1; observe(64'(fa1)); observe(64'(fb1)); observe(64'(stall1));
    observe(64'(sc1)); observe(64'(sc2));
    tick();
    wbData = 32'd0;
    repeat (4) tick();

    // two-bubble instance: lw r3 -> add r4,r5,r3 forwards from LATE
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    tick();
    drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    push("lu2_stall_c1", 64'd1); #1; observe(64'(stall2));
    tick();
    push("lu2_stall_c2", 64'd1); #1; observe(64'(stall2));
    tick();
    wbData = 32'h1234_5678;
    push("lu2_stall_c3", 64'd0); #1; observe(64'(stall2));
    tick();
    idle(); wbData = 32'hFFFF_0000;
    push("lu2_fwdB", 64'd3); push("lu2_fwdA", 64'd0); push("lu2_late", 64'h1234_5678);
    push("lu2_scnt_sat", 64'd3); push("lu2_d1_scnt", 64'd2);
    #1; observe(64'(fb2)); observe(64'(fa2)); observe(64'(late2));
    observe(64'(sc2)); observe(64'(sc1));
    tick();
    wbData = 32'd0;
    repeat (4) tick();

    // lw r0 -> read r0 twice: r0 never matches
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    push("r0_stall", 64'd0); push("r0_d2_stall", 64'd0);
    #1; observe(64'(stall1)); observe(64'(stall2));
    tick();
    idle();
    push("r0_fwdA", 64'd0); push("r0_fwdB", 64'd0);
    #1; observe(64'(fa1)); observe(64'(fb1));
    repeat (4) tick();

    // branch in MEM taken while load-use hazard sits in ID
    drive(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    brTaken = 1'b1;
    push("br_flush", 64'd1); push("br_stall", 64'd0);
    push("br_d2_flush", 64'd1); push("br_d2_stall", 64'd0);
    #1; observe(64'(flush1)); observe(64'(stall1)); observe(64'(flush2)); observe(64'(stall2));
    tick();
    brTaken = 1'b0;
    drive(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    push("br_flush_after", 64'd0); push("br_stall_after", 64'd0);
    push("br_fcnt", 64'd1); push("br_d2_fcnt", 64'd1);
    #1; observe(64'(flush1)); observe(64'(stall1)); observe(64'(fc1)); observe(64'(fc2));
    tick();
    idle();
    push("br_ex_bubble_fwdA", 64'd0); push("br_mem_bubble_fwdB", 64'd0);
    #1; observe(64'(fa1)); observe(64'(fb1));
    repeat (4) tick();

    // asynchronous reset in the middle of a two-cycle stall
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
    push("ar_stall_c1", 64'd1); #1; observe(64'(stall2));
    tick();
    push("ar_stall_c2", 64'd1); #1; observe(64'(stall2));
    #2;
    rst = 1'b1;
    #1;
    push("ar_d1_stall", 64'd0); push("ar_d2_stall", 64'd0);
    push("ar_d1_scnt", 64'd0); push("ar_d2_scnt", 64'd0); push("ar_d2_late", 64'd0);
    observe(64'(stall1)); observe(64'(stall2)); observe(64'(sc1)); observe(64'(sc2));
    observe(64'(late2));
    idle();
    tick();
    rst = 1'b0;
    tick();

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_NUM_WIDTH, default 5, giving the register-number width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the datapath width.
REQ-003 The block SHALL have parameter LOAD_STALL_CYCLES, default 1, legal range 1..7, giving the number of bubbles inserted per load-use hazard.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32, giving the width of each statistics counter.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 idValid  in  1  the ID slot holds a real instruction.
REQ-009 idRs, idRt  in  REG_NUM_WIDTH each  source register numbers of the ID instruction.
REQ-010 idRsUsed, idRtUsed  in  1 each  the corresponding source is actually read.
REQ-011 idWrEnable  in  1  the ID instruction writes a register.
REQ-012 idWrNum  in  REG_NUM_WIDTH  destination register of the ID instruction.
REQ-013 idIsLoad  in  1  the ID instruction is a load.
REQ-014 brTaken  in  1  the branch in MEM redirects the PC this cycle.
REQ-015 wbData  in  DATA_WIDTH  value being written to the register file this cycle.
REQ-016 stall  out  1  hold the PC and the IF/ID register; inject a bubble into ID/EX.
REQ-017 flush  out  1  squash the IF/ID, ID/EX and EX/MEM registers at the next edge.
REQ-018 fwdSelA, fwdSelB  out  2 each  ALU operand source for the EX instruction: 00 register file, 01 MEM ALU result, 10 WB write data, 11 lateData.
REQ-019 lateData  out  DATA_WIDTH  register value written back one cycle earlier.
REQ-020 stallCount, flushCount  out  CNT_WIDTH each  statistics counters.

Function
REQ-021 The block SHALL hold one shadow record per stage for EX, MEM, WB and LATE (one cycle past WB); each record holds valid, wrEnable, wrNum and isLoad, and the EX record also holds rs, rt, rsUsed and rtUsed.
REQ-022 On every edge the records SHALL shift: EX gets the ID fields, MEM gets EX, WB gets MEM, LATE gets WB; lateData SHALL load wbData only when the WB record is valid with wrEnable=1.
REQ-023 A source SHALL be treated as matching a record only if the source is used and nonzero, and the record is valid, has wrEnable=1, and has an equal wrNum; register 0 SHALL never match.
REQ-024 hazard SHALL be 1 when idValid=1 and either ID source matches an EX record with isLoad=1.
REQ-025 stall SHALL be the combinational value (hazard OR stallCnt!=0) AND NOT flush.
REQ-026 On an edge where hazard=1 and stallCnt=0, stallCnt SHALL load LOAD_STALL_CYCLES-1; while stallCnt is nonzero it SHALL decrement by 1 per edge.
REQ-027 When stall=1, the EX record SHALL receive a bubble (valid=0) instead of the ID fields.
REQ-028 flush SHALL equal brTaken AND MEM-record valid.
REQ-029 When flush=1, stall SHALL be 0, stallCnt SHALL clear, and the EX and MEM records SHALL receive bubbles at the next edge.
REQ-030 fwdSelA SHALL be computed per source of the EX record, with priority MEM match (isLoad=0) -> 01, else WB match -> 10, else LATE match -> 11, else 00; fwdSelB SHALL follow the same rules.
REQ-031 A MEM-record match with isLoad=1 SHALL yield 00 (unreachable while LOAD_STALL_CYCLES>=1).
REQ-032 stallCount SHALL increment on each edge with stall=1, and flushCount on each edge with flush=1; both SHALL saturate at all-ones.

Reset
REQ-033 While rst=1, all record valids, stallCnt, lateData and both counters SHALL be 0, giving outputs stall=0, flush=0, fwdSelA=fwdSelB=00, lateData=0 and counts=0.
REQ-034 Asserting rst mid-stall or mid-flush SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-035 Sequence add r1 followed by add r2,r1,r3 -> consumer in EX sees fwdSelA=01, stall never asserts.
REQ-036 Sequence lw r3 followed by add r4,r3,r5 -> stall=1 for exactly 1 cycle, consumer in EX with fwdSelA=10, stallCount=1.
REQ-037 With LOAD_STALL_CYCLES=2, sequence lw r3 followed by add r4,r5,r3 -> stall=1 for 2 cycles, then fwdSelB=11 with lateData equal to the loaded value.
REQ-038 Sequence writing r0 followed by reading r0 -> fwdSel=00, no stall.
REQ-039 brTaken=1 with valid MEM while a load-use hazard exists in ID -> flush=1, stall=0, EX/MEM records invalid next cycle, flushCount=1.
REQ-040 rst asserted during a stall with no clock edge -> stall=0 and stallCount=0 immediately.
